// File: rtl/clock_pkg.sv
// Shared widths, BCD limits and state encoding for the time-of-day counter.
// Hour limits depend on the 12/24 hour mode.
package clock_pkg;

    localparam int HOURS_W   = 6;
    localparam int MINUTES_W = 7;
    localparam int SECONDS_W = 7;

    localparam logic [SECONDS_W-1:0] BCD_SEC_MAX = 7'h59;
    localparam logic [MINUTES_W-1:0] BCD_MIN_MAX = 7'h59;
    localparam logic [HOURS_W-1:0]   BCD_23      = 6'h23;
    localparam logic [HOURS_W-1:0]   BCD_12      = 6'h12;
    localparam logic [HOURS_W-1:0]   BCD_11      = 6'h11;
    localparam logic [HOURS_W-1:0]   BCD_01      = 6'h01;
    localparam logic [HOURS_W-1:0]   BCD_00      = 6'h00;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    function automatic logic [HOURS_W-1:0] hours_min(int hours_mod);
        return (hours_mod == 12) ? BCD_01 : BCD_00;
    endfunction

    function automatic logic [HOURS_W-1:0] hours_max(int hours_mod);
        return (hours_mod == 12) ? BCD_12 : BCD_23;
    endfunction

    function automatic logic [HOURS_W-1:0] hours_rst(int hours_mod);
        return (hours_mod == 12) ? BCD_12 : BCD_00;
    endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD counter with configurable min/max/reset values.
// Any out-of-range or non-BCD content wraps to MIN_VAL on the next increment.
module bcd_counter_2d
    import clock_pkg::*;
#(
    parameter int             W       = 7,
    parameter logic [W-1:0]   MAX_VAL = 'h59,
    parameter logic [W-1:0]   MIN_VAL = '0,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic [W-1:0] o_value,
    output logic         o_carry
);

    localparam logic [W-5:0] TENS_ONE = 1;

    logic [3:0]   ones;
    logic [W-5:0] tens;
    logic [W-5:0] tens_inc;
    logic         wrap;
    logic [W-1:0] next_val;

    assign ones     = o_value[3:0];
    assign tens     = o_value[W-1:4];
    assign tens_inc = tens + TENS_ONE;
    assign wrap     = (o_value >= MAX_VAL) || (ones > 4'd9);
    assign o_carry  = i_inc & wrap;

    always_comb begin
        next_val = o_value;
        if (wrap) begin
            next_val = MIN_VAL;
        end else if (ones == 4'd9) begin
            next_val = {tens_inc, 4'd0};
        end else begin
            next_val = {tens, ones + 4'd1};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_value <= RST_VAL;
        end else if (i_clear) begin
            o_value <= RST_VAL;
        end else if (i_load) begin
            o_value <= i_load_val;
        end else if (i_inc) begin
            o_value <= next_val;
        end
    end

endmodule

// File: rtl/clock_time_counter.sv
// Time-of-day counter (hh:mm:ss, BCD) with RUN/SET modes.
// SET adjusts hours/minutes independently without carries between fields.
module clock_time_counter
    import clock_pkg::*;
#(
    parameter int HOURS_MOD = 24
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic                 i_1hz_stb,
    input  logic                 i_timeset_stb,
    input  logic                 i_set_hours,
    input  logic                 i_set_minutes,
    output logic [HOURS_W-1:0]   o_hours,
    output logic [MINUTES_W-1:0] o_minutes,
    output logic [SECONDS_W-1:0] o_seconds,
    output logic                 o_setting,
    output logic                 o_day_stb
);

    localparam logic [HOURS_W-1:0] H_MIN = hours_min(HOURS_MOD);
    localparam logic [HOURS_W-1:0] H_MAX = hours_max(HOURS_MOD);
    localparam logic [HOURS_W-1:0] H_RST = hours_rst(HOURS_MOD);

    state_t state;

    logic sel;
    logic in_run;
    logic in_set;
    logic enter_set;
    logic run_tick;
    logic set_tick;
    logic sec_inc;
    logic min_inc;
    logic hr_inc;
    logic sec_carry;
    logic min_carry;
    logic hr_carry;
    logic day_wrap;

    assign sel       = i_set_hours | i_set_minutes;
    assign in_run    = (state == ST_RUN);
    assign in_set    = (state == ST_SET);
    assign enter_set = i_en & in_run & sel;
    // Set entry wins over a coincident 1 Hz strobe
    assign run_tick  = i_en & in_run & ~sel & i_1hz_stb;
    assign set_tick  = i_en & in_set & i_timeset_stb;

    assign sec_inc = run_tick;
    assign min_inc = sec_carry | (set_tick & i_set_minutes);
    assign hr_inc  = (in_run & min_carry) | (set_tick & i_set_hours);

    generate
        if (HOURS_MOD == 12) begin : g_day12
            assign day_wrap = sec_carry & min_carry & (o_hours == BCD_11);
        end else begin : g_day24
            assign day_wrap = sec_carry & min_carry & hr_carry;
        end
    endgenerate

    bcd_counter_2d #(
        .W       (SECONDS_W),
        .MAX_VAL (BCD_SEC_MAX),
        .MIN_VAL ('0),
        .RST_VAL ('0)
    ) u_seconds (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (enter_set),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (sec_inc),
        .o_value    (o_seconds),
        .o_carry    (sec_carry)
    );

    bcd_counter_2d #(
        .W       (MINUTES_W),
        .MAX_VAL (BCD_MIN_MAX),
        .MIN_VAL ('0),
        .RST_VAL ('0)
    ) u_minutes (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (min_inc),
        .o_value    (o_minutes),
        .o_carry    (min_carry)
    );

    bcd_counter_2d #(
        .W       (HOURS_W),
        .MAX_VAL (H_MAX),
        .MIN_VAL (H_MIN),
        .RST_VAL (H_RST)
    ) u_hours (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (hr_inc),
        .o_value    (o_hours),
        .o_carry    (hr_carry)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_RUN;
            o_setting <= 1'b0;
            o_day_stb <= 1'b0;
        end else if (!i_en) begin
            o_day_stb <= 1'b0;
        end else begin
            o_day_stb <= day_wrap;
            unique case (state)
                ST_RUN: begin
                    if (sel) begin
                        state     <= ST_SET;
                        o_setting <= 1'b1;
                    end
                end
                ST_SET: begin
                    if (!sel) begin
                        state     <= ST_RUN;
                        o_setting <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    o_setting <= 1'b0;
                end
            endcase
        end
    end

endmodule
